// File: rtl/apb_master_bridge.sv
//------------------------------------------------------------------------------
// apb_master_bridge
//
// Turns a core-side request/grant/response bus into APB3 master transfers.
// One transfer is in flight at a time, sequenced by an IDLE/SETUP/ACCESS FSM.
// The response is a single-cycle rvalid_o pulse carrying read data and error.
//
// Optional feature macro: APB_MST_TIMEOUT_EN
//   defined   : ACCESS aborts with err_o=1 after TIMEOUT_CYCLES cycles without
//               pready_i (pready_i in the limit cycle still completes normally)
//   undefined : ACCESS waits for pready_i indefinitely
//
// Ports:
//   clk_i, rst_ni          clock (rising edge), async active-low reset
//   req_i, addr_i, we_i,   core request; held with payload until gnt_o
//   wdata_i
//   gnt_o                  request accepted this cycle (combinational)
//   rvalid_o, rdata_o,     one-cycle response; rdata_o is 0 for writes,
//   err_o                  rdata_o/err_o hold until the next response
//   paddr_o, pwdata_o,     registered APB address / write data / direction
//   pwrite_o
//   psel_o, penable_o      APB phase controls
//   prdata_i, pready_i,    APB slave return path, sampled only when
//   pslverr_i              ACCESS completes
//------------------------------------------------------------------------------
module apb_master_bridge #(
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   // core side
   input  logic                      req_i,
   input  logic [APB_ADDR_WIDTH-1:0] addr_i,
   input  logic                      we_i,
   input  logic [APB_DATA_WIDTH-1:0] wdata_i,
   output logic                      gnt_o,
   output logic                      rvalid_o,
   output logic [APB_DATA_WIDTH-1:0] rdata_o,
   output logic                      err_o,
   // APB side
   output logic [APB_ADDR_WIDTH-1:0] paddr_o,
   output logic [APB_DATA_WIDTH-1:0] pwdata_o,
   output logic                      pwrite_o,
   output logic                      psel_o,
   output logic                      penable_o,
   input  logic [APB_DATA_WIDTH-1:0] prdata_i,
   input  logic                      pready_i,
   input  logic                      pslverr_i
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   state_t state;

`ifdef APB_MST_TIMEOUT_EN
   // Count value seen in the last allowed ACCESS cycle; reaching it with
   // pready_i still low aborts the transfer.
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] wait_cnt;
`endif

   // Only combinational output: accept while idle.
   assign gnt_o = req_i && (state == ST_IDLE);

   // NOTE: every register in this block uses <= so all of them update from
   // the same pre-edge values; mixing in = here would create order-dependent
   // simulation and mismatch synthesis.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state     <= ST_IDLE;
         paddr_o   <= '0;
         pwdata_o  <= '0;
         pwrite_o  <= 1'b0;
         psel_o    <= 1'b0;
         penable_o <= 1'b0;
         rvalid_o  <= 1'b0;
         rdata_o   <= '0;
         err_o     <= 1'b0;
`ifdef APB_MST_TIMEOUT_EN
         wait_cnt  <= '0;
`endif
      end else begin
         // Response is a pulse: low unless a completion below raises it.
         rvalid_o <= 1'b0;

         case (state)
            ST_IDLE: begin
               psel_o    <= 1'b0;
               penable_o <= 1'b0;
               if (gnt_o) begin
                  paddr_o  <= addr_i;
                  pwdata_o <= wdata_i;
                  pwrite_o <= we_i;
                  psel_o   <= 1'b1;
                  state    <= ST_SETUP;
               end
            end

            ST_SETUP: begin
               penable_o <= 1'b1;
               state     <= ST_ACCESS;
`ifdef APB_MST_TIMEOUT_EN
               wait_cnt  <= '0;
`endif
            end

            ST_ACCESS: begin
               if (pready_i) begin
                  // Normal completion also wins over a coincident timeout.
                  state     <= ST_IDLE;
                  psel_o    <= 1'b0;
                  penable_o <= 1'b0;
                  rvalid_o  <= 1'b1;
                  err_o     <= pslverr_i;
                  rdata_o   <= pwrite_o ? '0 : prdata_i;
               end
`ifdef APB_MST_TIMEOUT_EN
               else if (wait_cnt == TO_LAST) begin
                  state     <= ST_IDLE;
                  psel_o    <= 1'b0;
                  penable_o <= 1'b0;
                  rvalid_o  <= 1'b1;
                  err_o     <= 1'b1;
                  rdata_o   <= '0;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
`endif
            end

            default: begin
               // Illegal encoding: drop back to IDLE without any activity.
               state     <= ST_IDLE;
               psel_o    <= 1'b0;
               penable_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
Converts a simple core-side request/grant/response bus into APB3 master transfers, so a processor or DMA port can drive an APB node as initiator. It sits upstream of the APB node's slave port and issues one APB transfer at a time through an IDLE/SETUP/ACCESS state machine. Responses are returned as a one-cycle rvalid pulse carrying read data and an error flag.

Parameters:
APB_ADDR_WIDTH, 32, width of addr_i and paddr_o
APB_DATA_WIDTH, 32, width of wdata_i, rdata_o, pwdata_o and prdata_i
TIMEOUT_CYCLES, 255, maximum ACCESS wait cycles; used only when APB_MST_TIMEOUT_EN is defined; legal range 1..65535

Ports:
clk_i  in  1  clock; all logic on the rising edge
rst_ni  in  1  asynchronous active-low reset
req_i  in  1  core request; held with its payload until gnt_o
addr_i  in  APB_ADDR_WIDTH  request address
we_i  in  1  1 = write, 0 = read
wdata_i  in  APB_DATA_WIDTH  write data
gnt_o  out  1  request accepted this cycle (combinational)
rvalid_o  out  1  one-cycle response pulse
rdata_o  out  APB_DATA_WIDTH  read data; 0 for writes
err_o  out  1  slave error (or timeout), valid with rvalid_o
paddr_o  out  APB_ADDR_WIDTH  APB address (registered)
pwdata_o  out  APB_DATA_WIDTH  APB write data (registered)
pwrite_o  out  1  APB direction (registered)
psel_o  out  1  APB select
penable_o  out  1  APB enable
prdata_i  in  APB_DATA_WIDTH  APB read data
pready_i  in  1  APB ready
pslverr_i  in  1  APB slave error

Behaviour:
- Reset: rst_ni low forces state IDLE asynchronously. All registered outputs go to 0: paddr_o, pwdata_o, pwrite_o, psel_o, penable_o, rvalid_o, rdata_o, err_o.
- Reset mid-transfer: the transfer is abandoned and no rvalid_o is generated for it.
- gnt_o = req_i AND (state == IDLE). It is the only combinational output.
- On gnt_o: capture addr_i into paddr_o, wdata_i into pwdata_o and we_i into pwrite_o, then go to SETUP.
- SETUP (exactly 1 cycle): psel_o=1, penable_o=0. Next state is ACCESS.
- ACCESS: psel_o=1, penable_o=1. Wait while pready_i=0; paddr_o, pwdata_o and pwrite_o stay stable.
- ACCESS completing (pready_i=1): go to IDLE. Next cycle: rvalid_o=1, err_o=pslverr_i, rdata_o = prdata_i for reads, 0 for writes. psel_o and penable_o return to 0 in that same cycle.
- rvalid_o is high for exactly 1 cycle and does not depend on req_i; the core has no backpressure on responses. rdata_o and err_o hold their values until the next response.
- Back-to-back: a new request can be granted in the same cycle rvalid_o is high (state is IDLE). Minimum transfer period is 3 cycles: grant, SETUP, ACCESS with pready_i=1.
- paddr_o, pwdata_o and pwrite_o keep their last values in IDLE; they are not cleared.
- prdata_i and pslverr_i are sampled only in ACCESS with pready_i=1.
- Inputs arriving while not IDLE are ignored; req_i stays pending and gnt_o=0.
- FSM encoding: IDLE=0, SETUP=1, ACCESS=2. Value 3 is illegal and recovers to IDLE on the next cycle with no outputs asserted.

Optional Feature:
APB_MST_TIMEOUT_EN
- Defined: a 16-bit counter clears on entry to ACCESS and increments each ACCESS cycle with pready_i=0. When the count reaches TIMEOUT_CYCLES without pready_i, the transfer aborts and the state goes to IDLE. The next cycle gives rvalid_o=1, err_o=1, rdata_o=0, with psel_o and penable_o low. If pready_i arrives in the same cycle the limit is reached, the normal completion wins.
- Not defined: no counter exists and ACCESS waits indefinitely for pready_i; TIMEOUT_CYCLES is unused.

Test Plan:
- Reset values: hold rst_ni=0 and toggle inputs -> every output is 0 and gnt_o=0 while req_i=0. Assert rst_ni low during ACCESS -> psel_o and penable_o drop immediately and no rvalid_o follows.
- Zero-wait write: req_i=1, we_i=1, addr_i=0x1A10_0004, wdata_i=0xCAFE_F00D, slave pready_i=1 -> gnt_o in cycle 0; cycle 1 psel_o=1/penable_o=0 with paddr_o=0x1A10_0004; cycle 2 penable_o=1; cycle 3 rvalid_o=1, err_o=0, rdata_o=0.
- Read with 3 wait states: addr_i=0x1A10_1000, slave returns prdata_i=0x1234_5678 after 3 cycles of pready_i=0 -> penable_o high for 4 cycles, address stable throughout, then rvalid_o with rdata_o=0x1234_5678.
- Slave error: read completing with pslverr_i=1 -> rvalid_o=1, err_o=1. The following error-free transfer returns err_o=0.
- Back-to-back: req_i held high for 4 zero-wait transfers -> a grant every 3 cycles, each grant coinciding with the previous rvalid_o, and exactly 4 rvalid_o pulses.
- Timeout (APB_MST_TIMEOUT_EN, TIMEOUT_CYCLES=8): slave never asserts pready_i -> abort after 8 ACCESS cycles, then rvalid_o=1, err_o=1, rdata_o=0. A repeat run with pready_i arriving in the 8th cycle gives a normal response with err_o=0.
